// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port fair memory arbiter (req/wr/addr/wdata in per port, gnt/done out per port, shared rdata, mem_* strobes, busy)
module mem_arbiter #(
  parameter int AWIDTH  = 5,
  parameter int DWIDTH  = 8,
  parameter int ACC_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [AWIDTH-1:0] addr0,
  input  logic [AWIDTH-1:0] addr1,
  input  logic [DWIDTH-1:0] wdata0,
  input  logic [DWIDTH-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DWIDTH-1:0] rdata,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              busy
);
  localparam int CW = $clog2(ACC_CYC) + 1;
  localparam logic [CW-1:0] LAST = CW'(ACC_CYC - 1);
  if (ACC_CYC < 1) begin : g_bad_acc
    $error("mem_arbiter: ACC_CYC must be at least 1");
  end
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic              last_q, wr_q, gnt0_q, gnt1_q, done0_q, done1_q, busy_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q, rdata_q;
  logic              win_d, fin_d;
  always_comb begin
    win_d = req1 & (~req0 | ~last_q);
    fin_d = (state_q == ACCESS) & (cnt_q == LAST);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      wr_q    <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (req0 | req1) begin
          state_q <= ACCESS;
          cnt_q   <= '0;
          last_q  <= win_d;
          gnt0_q  <= ~win_d;
          gnt1_q  <= win_d;
          busy_q  <= 1'b1;
          wr_q    <= win_d ? wr1 : wr0;
          addr_q  <= win_d ? addr1 : addr0;
          wdata_q <= win_d ? wdata1 : wdata0;
        end
        ACCESS: if (fin_d) begin
          state_q <= DONE;
          done0_q <= gnt0_q;
          done1_q <= gnt1_q;
          if (!wr_q) rdata_q <= mem_rdata;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign busy      = busy_q;
  assign rdata     = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_rd    = (state_q == ACCESS) & ~wr_q;
  assign mem_wr    = fin_d & wr_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vectors, corner sequences and random traffic against a transaction-level model
module tb_mem_arbiter;
  localparam int AW = 5, DW = 8, ACC = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic req0 = 0, req1 = 0, wr0 = 0, wr1 = 0;
  logic [AW-1:0] addr0 = 0, addr1 = 0, mem_addr;
  logic [DW-1:0] wdata0 = 0, wdata1 = 0, rdata, mem_wdata, mem_rdata;
  logic gnt0, gnt1, done0, done1, mem_rd, mem_wr, busy;
  int errors = 0, checks = 0;
  mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .ACC_CYC(ACC)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .busy(busy)
  );
  always #5 clk = ~clk;
  logic [DW-1:0] mem [32];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_wr) mem[mem_addr] = mem_wdata;
  int ph, own;
  logic mlast, mwr;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mwd, mrd;
  logic [DW-1:0] rmem [32];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    ph = 0; own = 0; mlast = 1'b1; mwr = 1'b0; maddr = '0; mwd = '0; mrd = '0;
  endtask
  // ph counts cycles since the grant: 1..ACC are the strobe cycles, ACC+1 is completion
  task automatic model_step();
    if (ph == 0) begin
      if (req0 || req1) begin
        own = (req0 && req1) ? (mlast ? 0 : 1) : (req0 ? 0 : 1);
        mlast = (own == 1);
        mwr   = own ? wr1 : wr0;
        maddr = own ? addr1 : addr0;
        mwd   = own ? wdata1 : wdata0;
        ph = 1;
      end
    end else if (ph <= ACC) begin
      if (ph == ACC) begin
        if (mwr) rmem[maddr] = mwd;
        else mrd = rmem[maddr];
      end
      ph++;
    end else ph = 0;
  endtask
  task automatic check_model();
    chk("gnt0", gnt0, ph != 0 && own == 0);
    chk("gnt1", gnt1, ph != 0 && own == 1);
    chk("done0", done0, ph == ACC + 1 && own == 0);
    chk("done1", done1, ph == ACC + 1 && own == 1);
    chk("mem_rd", mem_rd, ph >= 1 && ph <= ACC && !mwr);
    chk("mem_wr", mem_wr, ph == ACC && mwr);
    chk("busy", busy, ph != 0);
    chk("mem_addr", mem_addr, maddr);
    chk("mem_wdata", mem_wdata, mwd);
    chk("rdata", rdata, mrd);
    chk("gnt_excl", gnt0 & gnt1, 0);
  endtask
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_model();
  endtask
  task automatic idle_inputs();
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
  endtask
  typedef struct {
    logic r0, w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic r1, w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    logic [6:0] flags;
    logic [DW-1:0] erd;
  } vec_t;
  vec_t tv [12];
  int q [$];
  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i] = DW'($urandom);
      rmem[i] = mem[i];
    end
    mem[5] = 8'hA7; rmem[5] = 8'hA7;
    // flags = {gnt0, gnt1, done0, done1, mem_rd, mem_wr, busy}
    tv[0]  = '{1, 0, 5, 0, 0, 0, 0, 0, 7'b1000101, 8'h00};
    tv[1]  = '{1, 0, 5, 0, 0, 0, 0, 0, 7'b1000101, 8'h00};
    tv[2]  = '{1, 0, 5, 0, 0, 0, 0, 0, 7'b1010001, 8'hA7};
    tv[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 8'hA7};
    tv[4]  = '{0, 0, 0, 0, 1, 1, 5'h1F, 8'h3C, 7'b0100001, 8'hA7};
    tv[5]  = '{0, 0, 0, 0, 1, 1, 5'h1F, 8'h3C, 7'b0100011, 8'hA7};
    tv[6]  = '{0, 0, 0, 0, 1, 1, 5'h1F, 8'h3C, 7'b0101001, 8'hA7};
    tv[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 8'hA7};
    tv[8]  = '{0, 0, 0, 0, 1, 0, 5'h1F, 8'h00, 7'b0100101, 8'hA7};
    tv[9]  = '{0, 0, 0, 0, 1, 0, 5'h1F, 8'h00, 7'b0100101, 8'hA7};
    tv[10] = '{0, 0, 0, 0, 1, 0, 5'h1F, 8'h00, 7'b0101001, 8'h3C};
    tv[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 8'h3C};
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 12; i++) begin
      req0 = tv[i].r0; wr0 = tv[i].w0; addr0 = tv[i].a0; wdata0 = tv[i].d0;
      req1 = tv[i].r1; wr1 = tv[i].w1; addr1 = tv[i].a1; wdata1 = tv[i].d1;
      cycle();
      chk($sformatf("vec%0d_flags", i), {gnt0, gnt1, done0, done1, mem_rd, mem_wr, busy}, tv[i].flags);
      chk($sformatf("vec%0d_rdata", i), rdata, tv[i].erd);
    end
    chk("wr_addr_1f", mem_addr, 5'h1F);
    // continuous contention from reset
    do_reset();
    req0 = 1; req1 = 1; wr0 = 0; wr1 = 0; addr0 = 1; addr1 = 2;
    for (int i = 1; i <= 16; i++) begin
      cycle();
      if (done0) q.push_back(0);
      if (done1) q.push_back(1);
      chk("cont_done_slot", done0 | done1, i % 4 == 3);
    end
    chk("cont_count", q.size(), 4);
    for (int i = 0; i < q.size() && i < 4; i++) chk($sformatf("cont_order%0d", i), q[i], i % 2);
    // dropped request and address change after the grant
    idle_inputs();
    do_reset();
    req0 = 1; addr0 = 7;
    cycle();
    req0 = 0; addr0 = 9;
    cycle();
    chk("drop_addr_hold", mem_addr, 7);
    cycle();
    chk("drop_done0", done0, 1);
    cycle();
    // reset between edges during the strobe cycle of a write
    do_reset();
    req0 = 1; wr0 = 1; addr0 = 3; wdata0 = 8'h55;
    cycle();
    cycle();
    chk("rst_wr_before", mem_wr, 1);
    #1 rst = 1'b1;
    model_reset();
    #1;
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_gnt0", gnt0, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done0", done0, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_nowrite", mem[3], rmem[3]);
    req0 = 1; req1 = 1; wr0 = 0; wr1 = 0;
    cycle();
    chk("rst_tie_gnt0", gnt0, 1);
    chk("rst_tie_gnt1", gnt1, 0);
    // random traffic, requests and payload changing freely
    for (int i = 0; i < 600; i++) begin
      req0 = ($urandom_range(0, 3) != 0);
      req1 = ($urandom_range(0, 3) != 0);
      wr0 = $urandom_range(0, 1) == 1;
      wr1 = $urandom_range(0, 1) == 1;
      addr0 = AW'($urandom); addr1 = AW'($urandom);
      wdata0 = DW'($urandom); wdata1 = DW'($urandom);
      cycle();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter that shares the single VeriRISC data/instruction memory between the CPU controller (port 0) and a debug/program loader (port 1). It latches one request at a time, runs a fixed-length memory access, returns read data and a one-cycle completion pulse, and alternates fairly between the two ports when both are requesting. It sits between the requesters and the memory's address, data, `rd` and `wr` pins.

## Interface
- `AWIDTH`, 5: memory address width.
- `DWIDTH`, 8: memory data width.
- `ACC_CYC`, 2: cycles the memory strobe is held per access. Must be at least 1. A value below 1 is illegal and must be flagged at elaboration.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0` / `req1` in 1: access request. Must be held high until the matching `done` pulse.
- `wr0` / `wr1` in 1: 1 = write, 0 = read. Sampled with `req`.
- `addr0` / `addr1` in AWIDTH: access address.
- `wdata0` / `wdata1` in DWIDTH: write data.
- `gnt0` / `gnt1` out 1: port owns the memory.
- `done0` / `done1` out 1: one-cycle pulse when the access is complete.
- `rdata` out DWIDTH: read data from the last completed read, shared by both ports.
- `mem_addr` out AWIDTH: memory address.
- `mem_wdata` out DWIDTH: memory write data.
- `mem_rd` out 1: memory read strobe.
- `mem_wr` out 1: memory write strobe.
- `mem_rdata` in DWIDTH: memory read data, valid while `mem_rd` is high.
- `busy` out 1: an access is in progress (state is not IDLE).

## Operation
- FSM states are IDLE, ACCESS and DONE. A cycle counter of width clog2(ACC_CYC)+1 runs inside ACCESS. A `last` register holds the most recently served port.
- **Reset values.** State = IDLE, `last` = 1 so that port 0 wins the first tie. All outputs are 0: `gnt*`, `done*`, `mem_rd`, `mem_wr`, `mem_addr`, `mem_wdata`, `rdata`, `busy`.
- **IDLE to ACCESS** when any `req` is high.
  - Only one port requesting: that port wins.
  - Both ports requesting: the port that is not `last` wins.
  - On the transition, latch the winner's `addr`, `wdata` and `wr` into `mem_addr`, `mem_wdata` and an internal `wr_q`. Set the winner's `gnt`, set `busy`, clear the counter, and set `last` to the winner.
- **ACCESS** lasts exactly ACC_CYC cycles.
  - `mem_rd` = ~`wr_q` for all ACC_CYC cycles.
  - `mem_wr` = `wr_q` on the final ACCESS cycle only. Address and data are stable for at least ACC_CYC−1 cycles before the write strobe.
  - On the final cycle's edge, go to DONE. For a read, also load `rdata` from `mem_rdata`.
- **DONE** lasts one cycle.
  - The winner's `done` = 1; `gnt` stays 1; both strobes are 0.
  - On the next edge, go to IDLE and clear `gnt`, `done` and `busy`.
- `rdata` holds its value until the next completed read. Writes never change it.
- **Request changes during an access.** Requests are not re-sampled outside IDLE.
  - A `req` dropped mid-access does not abort; the access completes and `done` still pulses.
  - A `req` raised by the other port waits in IDLE until arbitrated.
  - Address and data changes made by the owner after the grant are ignored.
- Only one `gnt` is ever high. `mem_rd` and `mem_wr` are never high together.
- **Reset mid-access.** All outputs clear asynchronously (no strobe glitch is extended) and state returns to IDLE. The interrupted access is lost with no `done` pulse.

## Timing
- Outputs are registered, except that `mem_rd` and `mem_wr` are decoded from state and counter registers only, with no input-to-output path.
- Take `req` sampled high in IDLE at edge E.
  - ACCESS occupies cycles E+1 through E+ACC_CYC.
  - `done` is high in cycle E+ACC_CYC+1.
  - IDLE resumes at cycle E+ACC_CYC+2.
- Request-to-done latency is ACC_CYC+1 cycles. Minimum access period is ACC_CYC+2 cycles.
- With ACC_CYC=2 this gives a latency of 3 cycles and a period of 4 cycles.
- Under continuous contention, grants strictly alternate 0,1,0,1…. No port waits more than one access.

## Test plan
- **Single read, port 0.** ACC_CYC=2, mem[5]=8'hA7; `req0`=1, `wr0`=0, `addr0`=5.
  - `gnt0` rises after the first edge. `mem_rd` is high 2 cycles and `mem_wr` never rises.
  - `done0` pulses 3 cycles after the request is sampled, with `rdata`=8'hA7.
- **Single write, port 1.** `addr1`=5'h1F, `wdata1`=8'h3C, `wr1`=1.
  - `mem_wr` is high only in the 2nd ACCESS cycle, with `mem_addr`=5'h1F.
  - `done1` pulses; a read-back of 5'h1F returns 8'h3C; `rdata` is unchanged by the write.
- **Contention from reset.** Both `req`s held continuously.
  - Grant order is 0,1,0,1.
  - `done0` and `done1` alternate with a 4-cycle spacing; `gnt0` and `gnt1` are never both high.
- **Dropped request.** `req0` deasserted in the 1st ACCESS cycle.
  - The access still completes and `done0` pulses.
  - Changing `addr0` after the grant does not change `mem_addr`.
- **Reset mid-access.** Assert `rst` in the 2nd ACCESS cycle of a write, between clock edges.
  - `mem_wr`, `gnt*` and `busy` drop immediately, with no `done`.
  - The next access starts from IDLE and port 0 wins a tie.
